// File: rtl/tda_distance_stream.sv
// tda_distance_stream
//   Buffers a point cloud (num_points x dimension signed coordinates) from a
//   word stream. It then emits the saturated squared Euclidean distance of
//   every unordered pair (i<j) in row-major order. Each result carries an
//   epsilon-neighbourhood flag.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   enable                   global freeze when low
//   point_data/valid/ready   coordinate word stream (low COORD_WIDTH bits used)
//   num_points, dimension    frame configuration, latched with the first word
//   epsilon                  unsigned neighbourhood threshold, latched with config
//   dist_data/i/j/within     pair result, held until accepted
//   dist_valid/ready         result handshake
//   busy, done, error_flag   status (error_flag sticky until rst)
module tda_distance_stream #(
    parameter int DATA_WIDTH    = 32,
    parameter int COORD_WIDTH   = 16,
    parameter int MAX_POINTS    = 64,
    parameter int MAX_DIMENSION = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] point_data,
    input  logic                  point_valid,
    output logic                  point_ready,
    input  logic [7:0]            num_points,
    input  logic [7:0]            dimension,
    input  logic [DATA_WIDTH-1:0] epsilon,
    output logic [DATA_WIDTH-1:0] dist_data,
    output logic [7:0]            dist_i,
    output logic [7:0]            dist_j,
    output logic                  dist_within,
    output logic                  dist_valid,
    input  logic                  dist_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error_flag
);
    localparam int DEPTH  = MAX_POINTS * MAX_DIMENSION;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SQ_W   = 2 * COORD_WIDTH + 2;
    // Extra headroom so the sum of MAX_DIMENSION squares never wraps.
    localparam int ACC_W  = SQ_W + $clog2(MAX_DIMENSION + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_EMIT, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [7:0]            n_reg, d_reg;
    logic [DATA_WIDTH-1:0] eps_reg;
    logic [7:0]            pt_reg, co_reg;          // load write position
    logic [7:0]            i_reg, j_reg, k_reg;     // pair / coordinate walk
    logic [ACC_W-1:0]      acc_reg;
    logic [DATA_WIDTH-1:0] dist_data_reg;
    logic [7:0]            dist_i_reg, dist_j_reg;
    logic                  within_reg;
    logic                  error_reg;

    // Point buffer, stride MAX_DIMENSION per point; no reset so it maps to RAM.
    logic [COORD_WIDTH-1:0] mem [DEPTH];

    logic                     in_hs, cfg_ok, load_last, calc_last, last_pair, wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [COORD_WIDTH-1:0]   coord_a, coord_b;
    logic signed [COORD_WIDTH:0] diff;
    logic signed [SQ_W-1:0]   diff_x, prod;
    logic [ACC_W-1:0]         acc_sum;
    logic [DATA_WIDTH-1:0]    sat_val;
    logic                     unused_hi;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] p, input logic [7:0] c);
        return ADDR_W'(p) * ADDR_W'(MAX_DIMENSION) + ADDR_W'(c);
    endfunction

    assign unused_hi   = &{1'b0, point_data[DATA_WIDTH-1:COORD_WIDTH]};

    assign point_ready = enable && !rst && (state_reg == S_IDLE || state_reg == S_LOAD);
    assign in_hs       = point_valid && point_ready;
    assign cfg_ok      = (num_points >= 8'd2) && (num_points <= 8'(MAX_POINTS))
                      && (dimension  >= 8'd1) && (dimension  <= 8'(MAX_DIMENSION));
    assign load_last   = (pt_reg == n_reg - 8'd1) && (co_reg == d_reg - 8'd1);
    assign calc_last   = (k_reg == d_reg - 8'd1);
    assign last_pair   = (i_reg == n_reg - 8'd2) && (j_reg == n_reg - 8'd1);

    // The very first word of a frame always lands at point 0, coord 0.
    assign wr_en   = in_hs && (state_reg == S_LOAD || (state_reg == S_IDLE && cfg_ok));
    assign wr_addr = (state_reg == S_IDLE) ? '0 : addr_of(pt_reg, co_reg);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= point_data[COORD_WIDTH-1:0];
        end
    end

    // Distance datapath: one coordinate difference squared per CALC cycle.
    always_comb begin
        coord_a = mem[addr_of(i_reg, k_reg)];
        coord_b = mem[addr_of(j_reg, k_reg)];
        diff    = {coord_a[COORD_WIDTH-1], coord_a} - {coord_b[COORD_WIDTH-1], coord_b};
        diff_x  = SQ_W'(diff);
        prod    = diff_x * diff_x;
        acc_sum = acc_reg + ACC_W'($unsigned(prod));
        if (acc_sum[ACC_W-1:DATA_WIDTH] != '0) begin
            sat_val = '1;
        end else begin
            sat_val = acc_sum[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_hs && cfg_ok)    state_next = S_LOAD;
            S_LOAD: if (in_hs && load_last) state_next = S_CALC;
            S_CALC: if (calc_last)          state_next = S_EMIT;
            S_EMIT: if (dist_ready)         state_next = last_pair ? S_DONE : S_CALC;
            S_DONE:                         state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            n_reg         <= '0;
            d_reg         <= '0;
            eps_reg       <= '0;
            pt_reg        <= '0;
            co_reg        <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            dist_data_reg <= '0;
            dist_i_reg    <= '0;
            dist_j_reg    <= '0;
            within_reg    <= 1'b0;
            error_reg     <= 1'b0;
        end else if (enable) begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_hs) begin
                        n_reg   <= num_points;
                        d_reg   <= dimension;
                        eps_reg <= epsilon;
                        if (!cfg_ok) begin
                            error_reg <= 1'b1;
                        end else if (dimension == 8'd1) begin
                            pt_reg <= 8'd1;
                            co_reg <= 8'd0;
                        end else begin
                            pt_reg <= 8'd0;
                            co_reg <= 8'd1;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_hs) begin
                        if (co_reg == d_reg - 8'd1) begin
                            co_reg <= 8'd0;
                            pt_reg <= pt_reg + 8'd1;
                        end else begin
                            co_reg <= co_reg + 8'd1;
                        end
                        if (load_last) begin
                            i_reg   <= 8'd0;
                            j_reg   <= 8'd1;
                            k_reg   <= 8'd0;
                            acc_reg <= '0;
                        end
                    end
                end
                S_CALC: begin
                    if (calc_last) begin
                        dist_data_reg <= sat_val;
                        dist_i_reg    <= i_reg;
                        dist_j_reg    <= j_reg;
                        within_reg    <= (sat_val <= eps_reg);
                    end else begin
                        acc_reg <= acc_sum;
                        k_reg   <= k_reg + 8'd1;
                    end
                end
                S_EMIT: begin
                    if (dist_ready) begin
                        k_reg   <= 8'd0;
                        acc_reg <= '0;
                        if (!last_pair) begin
                            if (j_reg == n_reg - 8'd1) begin
                                i_reg <= i_reg + 8'd1;
                                j_reg <= i_reg + 8'd2;
                            end else begin
                                j_reg <= j_reg + 8'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dist_valid  = (state_reg == S_EMIT);
    assign dist_data   = dist_data_reg;
    assign dist_i      = dist_i_reg;
    assign dist_j      = dist_j_reg;
    assign dist_within = within_reg;
    assign busy        = (state_reg == S_LOAD) || (state_reg == S_CALC) || (state_reg == S_EMIT);
    assign done        = (state_reg == S_DONE);
    assign error_flag  = error_reg;

endmodule

// File: tb/tb_tda_distance_stream.sv
module tb_tda_distance_stream;
    logic        clk = 1'b0;
    logic        rst, enable, point_valid, dist_ready;
    logic [31:0] point_data, epsilon, dist_data;
    logic [7:0]  num_points, dimension, dist_i, dist_j;
    logic        point_ready, dist_within, dist_valid, busy, done, error_flag;

    always #5 clk = ~clk;

    tda_distance_stream dut (
        .clk(clk), .rst(rst), .enable(enable),
        .point_data(point_data), .point_valid(point_valid), .point_ready(point_ready),
        .num_points(num_points), .dimension(dimension), .epsilon(epsilon),
        .dist_data(dist_data), .dist_i(dist_i), .dist_j(dist_j),
        .dist_within(dist_within), .dist_valid(dist_valid), .dist_ready(dist_ready),
        .busy(busy), .done(done), .error_flag(error_flag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame description used by run_frame / check_frame.
    int          cfg_n, cfg_d;
    logic [31:0] cfg_eps;
    int          coord [64][3];
    bit          rand_ready, rand_valid, frz_load, frz_emit;
    int          stop_after;

    logic [31:0] got_d[$];
    int          got_i[$], got_j[$], hs_it[$];
    bit          got_w[$];
    int          first_valid_it, last_load_it, done_cnt;

    task automatic set_cfg(input int n, input int d, input logic [31:0] e);
        cfg_n = n; cfg_d = d; cfg_eps = e;
        rand_ready = 0; rand_valid = 0; frz_load = 0; frz_emit = 0; stop_after = 0;
    endtask

    // Drives one frame cycle by cycle: inputs change on the falling edge,
    // handshakes are decided from what is presented before the next rising edge.
    task automatic run_frame();
        int nw = cfg_n * cfg_d;
        int widx = 0;
        int frz = 0;
        bit did_fl = 0, did_fe = 0, prev_stall = 0;
        logic [31:0] pd = '0;
        logic [15:0] pij = '0;
        logic pw = 1'b0;
        int done_it = -1;
        got_d.delete(); got_i.delete(); got_j.delete(); got_w.delete(); hs_it.delete();
        first_valid_it = -1; last_load_it = -1; done_cnt = 0;
        for (int it = 0; it < 20000; it++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", dist_valid, 1);
                check("stall_data", dist_data, pd);
                check("stall_ij", {dist_i, dist_j}, pij);
                check("stall_within", dist_within, pw);
            end
            if (!enable) begin
                check("frz_ready", point_ready, 0);
                check("frz_busy", busy, 1);
            end
            if (dist_valid && first_valid_it < 0) first_valid_it = it;
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                if (done_it < 0) done_it = it;
            end
            if (done_it >= 0 && it >= done_it + 3) break;
            if (frz == 0 && frz_load && !did_fl && widx == 2) begin frz = 10; did_fl = 1; end
            if (frz == 0 && frz_emit && !did_fe && dist_valid) begin frz = 10; did_fe = 1; end
            enable = (frz == 0);
            if (frz > 0) frz--;
            point_valid = (widx < nw) && (!rand_valid || $urandom_range(0, 3) != 0);
            if (widx < nw)
                point_data = {16'($urandom), 16'(coord[widx / cfg_d][widx % cfg_d])};
            num_points = (widx == 0) ? 8'(cfg_n) : 8'($urandom);
            dimension  = (widx == 0) ? 8'(cfg_d) : 8'($urandom);
            epsilon    = (widx == 0) ? cfg_eps   : $urandom;
            dist_ready = !enable ? 1'b1 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            if (point_valid && point_ready) begin
                if (widx == nw - 1) last_load_it = it;
                widx++;
            end
            prev_stall = dist_valid && !(dist_ready && enable);
            pd = dist_data; pij = {dist_i, dist_j}; pw = dist_within;
            if (dist_valid && dist_ready && enable) begin
                got_d.push_back(dist_data); got_i.push_back(int'(dist_i));
                got_j.push_back(int'(dist_j)); got_w.push_back(dist_within);
                hs_it.push_back(it);
                $display("pair (%0d,%0d) dist=%0h within=%0b", dist_i, dist_j, dist_data, dist_within);
                if (stop_after > 0 && got_d.size() == stop_after) begin
                    @(posedge clk);
                    #2;
                    point_valid = 1'b0;
                    return;
                end
            end
        end
        point_valid = 1'b0;
        enable = 1'b1;
        check("frame_done_seen", done_it >= 0, 1);
    endtask

    // Reference: squared distances of all pairs i<j in row-major order.
    task automatic check_frame(input string tag);
        int np = 0;
        for (int i = 0; i < cfg_n; i++) begin
            for (int j = i + 1; j < cfg_n; j++) begin
                longint s = 0;
                logic [31:0] e;
                for (int k = 0; k < cfg_d; k++) begin
                    longint df = longint'(coord[i][k]) - longint'(coord[j][k]);
                    s += df * df;
                end
                e = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
                if (np < got_d.size()) begin
                    check({tag, "_data"}, got_d[np], e);
                    check({tag, "_ij"}, {got_i[np], got_j[np]}, {i, j});
                    check({tag, "_within"}, got_w[np], e <= cfg_eps);
                end
                np++;
            end
        end
        check({tag, "_count"}, got_d.size(), np);
        check({tag, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic load_basic();
        set_cfg(3, 2, 32'd25);
        coord[0][0] = 0; coord[0][1] = 0;
        coord[1][0] = 3; coord[1][1] = 4;
        coord[2][0] = 6; coord[2][1] = 8;
    endtask

    task automatic bad_cfg(input string tag, input int n, input int d);
        @(negedge clk);
        enable = 1'b1; point_valid = 1'b1; num_points = 8'(n); dimension = 8'(d);
        point_data = $urandom; epsilon = $urandom;
        #1;
        check({tag, "_consumed"}, point_ready, 1);
        @(negedge clk);
        point_valid = 1'b0;
        check({tag, "_err"}, error_flag, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_idle"}, point_ready, 1);
        check({tag, "_novalid"}, dist_valid, 0);
        $display("bad config n=%0d d=%0d error_flag=%0b", n, d, error_flag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pready"}, point_ready, 0);
        check({tag, "_dvalid"}, dist_valid, 0);
        check({tag, "_ddata"}, dist_data, 0);
        check({tag, "_dij"}, {dist_i, dist_j}, 0);
        check({tag, "_within"}, dist_within, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error_flag, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; point_valid = 1'b0; dist_ready = 1'b0;
        point_data = '0; epsilon = '0; num_points = '0; dimension = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, ready held high: latency and spacing.
        load_basic();
        run_frame();
        check_frame("basic");
        check("basic_latency", first_valid_it - last_load_it, cfg_d + 1);
        for (int p = 1; p < hs_it.size(); p++)
            check("basic_spacing", hs_it[p] - hs_it[p-1], cfg_d + 1);

        // Saturation.
        set_cfg(2, 3, 32'h1000);
        for (int k = 0; k < 3; k++) begin coord[0][k] = -32768; coord[1][k] = 32767; end
        run_frame();
        check_frame("sat");
        check("sat_err", error_flag, 0);

        // Configuration errors, then a good frame.
        bad_cfg("bad_n1", 1, 2);
        bad_cfg("bad_d4", 3, 4);
        bad_cfg("bad_n65", 65, 1);
        bad_cfg("bad_d0", 4, 0);
        load_basic();
        run_frame();
        check_frame("after_err");
        check("err_sticky", error_flag, 1);

        // Backpressure.
        load_basic();
        rand_ready = 1;
        run_frame();
        check_frame("bp");

        // Enable freeze in LOAD and in EMIT.
        load_basic();
        frz_load = 1; frz_emit = 1;
        run_frame();
        check_frame("freeze");

        // Reset after two of three results.
        load_basic();
        stop_after = 2;
        run_frame();
        check("rst_got2", got_d.size(), 2);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        set_cfg(2, 1, 32'd63);
        coord[0][0] = 5; coord[1][0] = -3;
        run_frame();
        check_frame("fresh");
        check("fresh_value", got_d.size() > 0 ? got_d[0] : 32'hDEAD, 64);

        // Randomized frames with random handshakes.
        for (int r = 0; r < 5; r++) begin
            set_cfg($urandom_range(2, 10), $urandom_range(1, 3),
                    ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 50000)) : $urandom);
            for (int p = 0; p < cfg_n; p++)
                for (int k = 0; k < 3; k++)
                    coord[p][k] = int'($urandom_range(0, 65535)) - 32768;
            rand_ready = 1; rand_valid = 1;
            run_frame();
            check_frame("rand");
        end

        // Largest frame.
        set_cfg(64, 3, $urandom);
        for (int p = 0; p < 64; p++)
            for (int k = 0; k < 3; k++)
                coord[p][k] = int'($urandom_range(0, 65535)) - 32768;
        run_frame();
        check_frame("max");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tda_distance_stream.md
# tda_distance_stream

Upstream neighbour of `tda_acceleration_unit`. It accepts the raw coordinate word stream for a point cloud and buffers `num_points` points of `dimension` coordinates each. It then emits one squared Euclidean distance per unordered point pair (i<j), in row-major order, with an epsilon-neighbourhood flag. Its output stream feeds the filtration/persistence engine through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: coordinate input word width and distance output width.
- `COORD_WIDTH`, 16: signed coordinate taken from `point_data[COORD_WIDTH-1:0]`; upper bits ignored.
- `MAX_POINTS`, 64: point buffer capacity.
- `MAX_DIMENSION`, 3: maximum coordinates per point.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, the block freezes; no state, counter or handshake advances.
- `point_data` in DATA_WIDTH: coordinate word.
- `point_valid` in 1 / `point_ready` out 1: input handshake.
- `num_points` in 8, `dimension` in 8: frame configuration, latched on the first accepted word.
- `epsilon` in DATA_WIDTH: unsigned threshold, latched with config.
- `dist_data` out DATA_WIDTH: saturated squared distance.
- `dist_i` out 8, `dist_j` out 8: pair indices, i<j.
- `dist_within` out 1: `dist_data <= epsilon`, unsigned compare.
- `dist_valid` out 1 / `dist_ready` in 1: output handshake.
- `busy` out 1: high in LOAD, CALC and EMIT.
- `done` out 1: one-cycle pulse after the last pair handshake.
- `error_flag` out 1: sticky config error, cleared only by `rst`.

## Operation
- States: IDLE, LOAD, CALC, EMIT, DONE.
- `point_ready` = `enable && (IDLE || LOAD) && !rst`.
- IDLE: on an input handshake, latch `num_points`, `dimension` and `epsilon`.
  - Config is valid when 2<=N<=MAX_POINTS and 1<=D<=MAX_DIMENSION.
  - Valid config: store the word as point 0, coord 0, and go to LOAD. If N*D==1 were possible it would skip LOAD, but it cannot occur because N>=2.
  - Invalid config: drop the word, set `error_flag`, stay in IDLE.
- LOAD: store words in point-major order (p0c0, p0c1, …).
  - After N*D words have been accepted in total, go to CALC with i=0, j=1, k=0, acc=0.
  - Words beyond N*D are not accepted, because `point_ready` is low outside IDLE/LOAD.
- CALC: one coordinate per cycle.
  - diff = p[i][k] − p[j][k], signed COORD_WIDTH+1 bits.
  - acc += diff², unsigned, with acc at least 2·COORD_WIDTH+2 bits wide.
  - At k = D−1, register the result and go to EMIT.
- Saturation: if the final acc > 2^DATA_WIDTH−1, `dist_data` = all ones. This is not an error.
- EMIT: `dist_valid`=1, with `dist_data`, `dist_i`, `dist_j` and `dist_within` held stable until `dist_ready`.
  - On handshake, if (i,j) == (N−2,N−1), go to DONE.
  - Otherwise j++. If the old j was N−1, then i++ and j = i+1.
  - Reset acc and k to 0, then return to CALC.
- DONE: `done`=1 for one cycle, then go to IDLE. The buffer contents are not cleared.
- Total pairs per frame: N(N−1)/2.
- `enable` low in any state: hold everything. `dist_valid` stays asserted if in EMIT, and `done` is not lost (it is held in the DONE state until `enable` returns).
- Reset mid-operation returns to IDLE immediately and discards the partial frame.

## Timing
- Reset values: `point_ready` 0, `dist_valid` 0, `dist_data` 0, `dist_i` 0, `dist_j` 0, `dist_within` 0, `busy` 0, `done` 0, `error_flag` 0.
- Input: one word accepted per cycle when `point_valid` is high.
- First `dist_valid`: D+1 cycles after the clock edge of the last load handshake (D CALC cycles, then EMIT).
- Throughput with `dist_ready` held high: one pair per D+1 cycles.
- Output stalls add cycles one-for-one. Outputs do not change while `dist_valid && !dist_ready`.
- `done`: asserted in the cycle after the final EMIT handshake.
- `busy`: falls in the same cycle `done` rises.
- `error_flag`: rises the cycle after the rejected handshake.

## Test plan
- Basic frame:
  - Stimulus: N=3, D=2, epsilon=25, points (0,0), (3,4), (6,8), `dist_ready`=1.
  - Required: (0,1)=25 within=1; (0,2)=100 within=0; (1,2)=25 within=1; exactly one `done` pulse; each pair 3 cycles apart.
- Saturation:
  - Stimulus: N=2, D=3, points (−32768,−32768,−32768) and (32767,32767,32767).
  - Required: `dist_data`=32'hFFFFFFFF, within=0 for epsilon=32'h1000, `error_flag`=0.
- Config error:
  - Stimulus: first word with N=1, then separately with D=4.
  - Required: word consumed, `error_flag`=1, state stays IDLE, no `dist_valid`. A following valid frame still completes correctly with `error_flag` remaining 1.
- Backpressure:
  - Stimulus: the basic frame with `dist_ready` toggling 0/1 randomly.
  - Required: same 3 results in order; outputs stable throughout each stall.
- Enable freeze:
  - Stimulus: drop `enable` for 10 cycles during LOAD and again during EMIT.
  - Required: `point_ready`=0 and no state progress; `dist_valid` held during the EMIT freeze; results identical to the unfrozen run.
- Reset mid-operation:
  - Stimulus: assert `rst` after 2 of the 3 EMIT handshakes.
  - Required: all outputs return to their reset values asynchronously; a fresh N=2, D=1 frame with points 5 and −3 yields (0,1)=64.
